// File: rtl/mealy_seq_detect.sv
// mealy_seq_detect: loadable-pattern Mealy digit-sequence detector with KMP-style fallback.
// Define MATCH_CNT_EN to build the saturating match counter; otherwise match_count is tied to 0.
module mealy_seq_detect #(
  parameter int DIGIT_W = 3,
  parameter int SEQ_LEN = 4,
  parameter int OVERLAP = 1,
  parameter logic [SEQ_LEN*DIGIT_W-1:0] RESET_PAT = 12'o0703,
  parameter int CNT_W = 8,
  localparam int ST_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1
) (
  input  logic                       clk,
  input  logic                       clear,
  input  logic [DIGIT_W-1:0]         in,
  input  logic                       in_valid,
  input  logic                       pat_load,
  input  logic [SEQ_LEN*DIGIT_W-1:0] pattern_in,
  output logic                       out,
  output logic [ST_W-1:0]            outq,
  output logic [CNT_W-1:0]           match_count
);
  logic [SEQ_LEN*DIGIT_W-1:0] pat;
  logic [DIGIT_W-1:0] hist [SEQ_LEN-1];
  logic [DIGIT_W-1:0] win [SEQ_LEN];
  logic [DIGIT_W-1:0] pd [SEQ_LEN];
  logic [ST_W-1:0] nxt;
  logic ok;
  always_comb begin
    for (int i = 0; i < SEQ_LEN; i++) pd[i] = pat[(SEQ_LEN-1-i)*DIGIT_W +: DIGIT_W];
    for (int i = 0; i < SEQ_LEN-1; i++) win[i] = hist[i];
    win[SEQ_LEN-1] = in;
  end
  // longest prefix that ends on the incoming digit, never longer than the current state allows
  always_comb begin
    nxt = '0;
    ok = 1'b0;
    for (int j = 1; j < SEQ_LEN; j++) begin
      ok = (j <= int'(outq) + 1);
      for (int k = 0; k < j; k++) ok = ok & (win[SEQ_LEN-j+k] == pd[k]);
      if (ok) nxt = ST_W'(j);
    end
  end
  assign out = in_valid & ~pat_load & (outq == ST_W'(SEQ_LEN-1)) & (in == pd[SEQ_LEN-1]);
  always_ff @(posedge clk) begin
    if (!clear) begin
      outq <= '0;
      pat <= RESET_PAT;
      for (int i = 0; i < SEQ_LEN-1; i++) hist[i] <= '0;
    end else if (pat_load) begin
      outq <= '0;
      pat <= pattern_in;
    end else if (in_valid) begin
      outq <= (out && OVERLAP == 0) ? '0 : nxt;
      for (int i = 0; i < SEQ_LEN-2; i++) hist[i] <= hist[i+1];
      hist[SEQ_LEN-2] <= in;
    end
  end
`ifdef MATCH_CNT_EN
  always_ff @(posedge clk) begin
    if (!clear) match_count <= '0;
    else if (out && match_count != '1) match_count <= match_count + CNT_W'(1);
  end
`else
  assign match_count = '0;
`endif
endmodule

// File: tb/tb_mealy_seq_detect.sv
// tb_mealy_seq_detect: directed checks of an overlapping (u0) and a non-overlapping, 2-bit-counter (u1) detector.
module tb_mealy_seq_detect;
`ifdef MATCH_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic clear, in_valid, pat_load;
  logic [2:0] din;
  logic [11:0] pattern_in;
  logic out0, out1;
  logic [1:0] q0, q1;
  logic [7:0] cnt0;
  logic [1:0] cnt1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  mealy_seq_detect u0 (
    .clk(clk), .clear(clear), .in(din), .in_valid(in_valid), .pat_load(pat_load),
    .pattern_in(pattern_in), .out(out0), .outq(q0), .match_count(cnt0)
  );
  mealy_seq_detect #(.OVERLAP(0), .CNT_W(2)) u1 (
    .clk(clk), .clear(clear), .in(din), .in_valid(in_valid), .pat_load(pat_load),
    .pattern_in(pattern_in), .out(out1), .outq(q1), .match_count(cnt1)
  );
  function automatic logic [31:0] ce(input int n);
    return CNT_EN ? n : 0;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic dig(input logic [2:0] d, input logic e0, input logic e1,
                     input logic [1:0] qe0, input logic [1:0] qe1);
    din = d;
    in_valid = 1'b1;
    @(negedge clk);
    chk("out0", {31'd0, out0}, {31'd0, e0});
    chk("out1", {31'd0, out1}, {31'd0, e1});
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("q0", {30'd0, q0}, {30'd0, qe0});
    chk("q1", {30'd0, q1}, {30'd0, qe1});
  endtask
  task automatic idle(input logic [1:0] qe);
    din = 3'd3;
    in_valid = 1'b0;
    @(negedge clk);
    chk("idle_out0", {31'd0, out0}, 0);
    @(posedge clk); #1;
    chk("idle_q0", {30'd0, q0}, {30'd0, qe});
  endtask
  task automatic counts(input int n0, input int n1);
    chk("cnt0", {24'd0, cnt0}, ce(n0));
    chk("cnt1", {30'd0, cnt1}, ce(n1));
  endtask
  task automatic do_reset();
    clear = 1'b0;
    @(posedge clk); #1;
    clear = 1'b1;
  endtask
  initial begin
    clear = 1'b0; in_valid = 1'b0; pat_load = 1'b0; din = '0; pattern_in = '0;
    @(posedge clk); @(posedge clk); #1;
    clear = 1'b1;
    chk("rst_q0", {30'd0, q0}, 0);
    chk("rst_q1", {30'd0, q1}, 0);
    chk("rst_out0", {31'd0, out0}, 0);
    counts(0, 0);
    // default pattern o0703 with overlap back into 3
    dig(6, 0, 0, 0, 0); dig(0, 0, 0, 1, 1); dig(7, 0, 0, 2, 2); dig(0, 0, 0, 3, 3);
    dig(7, 0, 0, 2, 2); dig(0, 0, 0, 3, 3); dig(3, 1, 1, 0, 0);
    counts(1, 1);
    // idle cycles hold state
    dig(6, 0, 0, 0, 0); dig(0, 0, 0, 1, 1);
    idle(1); idle(1); idle(1);
    dig(7, 0, 0, 2, 2); dig(0, 0, 0, 3, 3); dig(7, 0, 0, 2, 2); dig(0, 0, 0, 3, 3);
    dig(3, 1, 1, 0, 0);
    counts(2, 2);
    // self-overlapping pattern o1111
    pattern_in = 12'o1111; pat_load = 1'b1;
    @(posedge clk); #1;
    pat_load = 1'b0;
    chk("load_q0", {30'd0, q0}, 0);
    chk("load_q1", {30'd0, q1}, 0);
    dig(1, 0, 0, 1, 1); dig(1, 0, 0, 2, 2); dig(1, 0, 0, 3, 3);
    dig(1, 1, 1, 3, 0); dig(1, 1, 0, 3, 1); dig(1, 1, 0, 3, 2);
    counts(5, 3);
    // clear beats a matching digit; pattern returns to o0703
    clear = 1'b0; din = 3'd1; in_valid = 1'b1;
    @(negedge clk);
    chk("clr_out0", {31'd0, out0}, 1);
    chk("clr_out1", {31'd0, out1}, 0);
    @(posedge clk); #1;
    clear = 1'b1; in_valid = 1'b0;
    chk("clr_q0", {30'd0, q0}, 0);
    chk("clr_q1", {30'd0, q1}, 0);
    counts(0, 0);
    dig(0, 0, 0, 1, 1); dig(7, 0, 0, 2, 2); dig(0, 0, 0, 3, 3); dig(3, 1, 1, 0, 0);
    counts(1, 1);
    dig(0, 0, 0, 1, 1); dig(7, 0, 0, 2, 2); dig(0, 0, 0, 3, 3);
    clear = 1'b0; din = 3'd3; in_valid = 1'b1;
    @(negedge clk);
    chk("clr2_out0", {31'd0, out0}, 1);
    chk("clr2_out1", {31'd0, out1}, 1);
    @(posedge clk); #1;
    clear = 1'b1; in_valid = 1'b0;
    chk("clr2_q0", {30'd0, q0}, 0);
    counts(0, 0);
    // pat_load drops a matching digit
    dig(0, 0, 0, 1, 1); dig(7, 0, 0, 2, 2); dig(0, 0, 0, 3, 3);
    pattern_in = 12'o0703; pat_load = 1'b1; din = 3'd3; in_valid = 1'b1;
    @(negedge clk);
    chk("pl_out0", {31'd0, out0}, 0);
    chk("pl_out1", {31'd0, out1}, 0);
    @(posedge clk); #1;
    pat_load = 1'b0; in_valid = 1'b0;
    chk("pl_q0", {30'd0, q0}, 0);
    chk("pl_q1", {30'd0, q1}, 0);
    counts(0, 0);
    dig(0, 0, 0, 1, 1); dig(7, 0, 0, 2, 2); dig(0, 0, 0, 3, 3); dig(3, 1, 1, 0, 0);
    counts(1, 1);
    // back-to-back matches; u1 counter saturates at 3
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      dig(0, 0, 0, 1, 1); dig(7, 0, 0, 2, 2); dig(0, 0, 0, 3, 3); dig(3, 1, 1, 0, 0);
      counts(i, (i > 3) ? 3 : i);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
